// File: rtl/if_fetch_stage.sv
// +--------------------------------------------------------------------------+
// | if_fetch_stage : MIPS instruction-fetch stage, PC register + IF/ID reg.  |
// | Optional macro IF_PERF_CNT_EN adds a 32-bit fetched-instruction counter. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] Addr,
  input  logic [31:0] Inst,
  output logic [31:0] IdInst,
  output logic [31:0] IdPC,
  output logic [31:0] IdPC4,
  output logic        IdValid,
  output logic [31:0] FetchCnt
);

  localparam logic [31:0] c_reset_pc = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0] r_pc;
  logic [31:0] r_id_inst;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;
  logic        r_id_valid;

  logic [31:0] w_pc_plus4;
  logic        w_capture;
  logic        w_bubble;

  assign w_pc_plus4 = r_pc + 32'd4;
  // Redirect outranks both Flush and Stall; Flush outranks Stall.
  assign w_bubble   = Redirect | Flush;
  assign w_capture  = ~Redirect & ~Flush & ~Stall;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_pc <= c_reset_pc;
    end else if (Redirect) begin
      r_pc <= {RedirectPC[31:2], 2'b00};
    end else if (w_capture) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IdPC/IdPC4 keep their last values across bubbles.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_id_inst  <= NOP_INST;
      r_id_pc    <= 32'h0;
      r_id_pc4   <= 32'h0;
      r_id_valid <= 1'b0;
    end else if (w_bubble) begin
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else if (w_capture) begin
      r_id_inst  <= Inst;
      r_id_pc    <= r_pc;
      r_id_pc4   <= w_pc_plus4;
      r_id_valid <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_fetch_cnt <= 32'h0;
    end else if (w_capture) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign FetchCnt = r_fetch_cnt;
`else
  assign FetchCnt = 32'h0;
`endif

  assign Addr    = r_pc;
  assign IdInst  = r_id_inst;
  assign IdPC    = r_id_pc;
  assign IdPC4   = r_id_pc4;
  assign IdValid = r_id_valid;

endmodule

`default_nettype wire
